sort_seq_ctrl: RTL

// - Sequencer for the insertion-sort cell array (DEPTH cells chained by GT).
// - Accepts a batch of up to DEPTH values on a valid/ready stream, broadcasts each value with a one-cycle sort strobe.
// - Then drains the sorted contents serially on an output stream and clears the array for the next batch.
// - Sits between the upstream data source and the sort array; owns the array's data_in, data_rdy and clear.

---
 rtl/sort_seq_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sort_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sort_seq_ctrl
// Purpose  : Sequencer for an insertion-sort cell array. It strobes each
//            accepted value into the array, then drains the sorted cells
//            serially and clears the array for the next batch.
// Config   : SORT_ASCEND_EN - when defined, drain in ascending order
//            (cell count-1 down to cell 0) instead of descending.
// Revision : 1.0 - initial release
// ============================================================================
module sort_seq_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        in_last,
    output logic                        in_ready,
    output logic [DATA_WIDTH-1:0]       sort_data,
    output logic                        sort_rdy,
    output logic                        sort_clr,
    input  logic [DEPTH*DATA_WIDTH-1:0] sort_vals,
    output logic                        out_valid,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        out_last,
    input  logic                        out_ready,
    output logic                        busy
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    // SETTLE is the one-cycle gap that lets the final sort_rdy pulse land
    // in the array before the first cell is read.
    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_CLEAR  = 2'd3
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      next_count;
    logic [IDX_W-1:0]      rd_idx;
    logic [IDX_W-1:0]      next_rd_idx;
    logic                  accept;
    logic [IDX_W-1:0]      top_idx;
    logic [IDX_W-1:0]      first_idx;
    logic [IDX_W-1:0]      last_idx;
    logic [IDX_W-1:0]      step_idx;
    logic [DATA_WIDTH-1:0] cell_val [DEPTH];

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_cell
            assign cell_val[i] = sort_vals[i*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign top_idx = IDX_W'(count - CNT_ONE);

`ifdef SORT_ASCEND_EN
    assign first_idx = top_idx;
    assign last_idx  = '0;
    assign step_idx  = rd_idx - IDX_ONE;
`else
    assign first_idx = '0;
    assign last_idx  = top_idx;
    assign step_idx  = rd_idx + IDX_ONE;
`endif

    assign out_data = cell_val[rd_idx];
    assign busy     = (state != ST_FILL) || (count != '0);

    always_comb begin
        next_state  = state;
        next_count  = count;
        next_rd_idx = rd_idx;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        sort_clr    = rst;
        accept      = 1'b0;

        case (state)
            ST_FILL: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    next_count = count + CNT_ONE;
                    if (in_last || (count == CNT_FULL)) begin
                        next_state = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                next_rd_idx = first_idx;
                next_state  = ST_DRAIN;
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                out_last  = (rd_idx == last_idx);
                if (out_ready) begin
                    if (rd_idx == last_idx) begin
                        next_state = ST_CLEAR;
                    end else begin
                        next_rd_idx = step_idx;
                    end
                end
            end
            ST_CLEAR: begin
                sort_clr    = 1'b1;
                next_count  = '0;
                next_rd_idx = '0;
                next_state  = ST_FILL;
            end
            default: begin
                next_state = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FILL;
            count     <= '0;
            rd_idx    <= '0;
            sort_rdy  <= 1'b0;
            sort_data <= '0;
        end else begin
            state    <= next_state;
            count    <= next_count;
            rd_idx   <= next_rd_idx;
            sort_rdy <= accept;
            if (accept) begin
                sort_data <= in_data;
            end
        end
    end

endmodule
`default_nettype wire
